// File: rtl/traffic_light_multi.sv
// traffic_light_multi: N-street traffic light controller with priority
// pre-emption, minimum-green guard, night (flashing yellow) mode and clock enable.
//   clk, rst (sync, active-high), en (freeze), night_mode, pri_req[N]
//   lamps[3N] ({red,yellow,green} per street), pri_lamp[N], active_idx, remaining
module traffic_light_multi #(
  parameter int unsigned NUM_STREETS   = 2,
  parameter int unsigned TICK_DIV      = 1,
  parameter int unsigned GREEN_TICKS   = 5,
  parameter int unsigned MIN_GREEN     = 2,
  parameter int unsigned YELLOW_TICKS  = 2,
  parameter int unsigned ALL_RED_TICKS = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     night_mode,
  input  logic [NUM_STREETS-1:0]   pri_req,
  output logic [3*NUM_STREETS-1:0] lamps,
  output logic [NUM_STREETS-1:0]   pri_lamp,
  output logic [2:0]               active_idx,
  output logic [CNT_W-1:0]         remaining
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_NIGHT
  } state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [PW-1:0]          presc;
  logic [2:0]             idx_n;
  logic [NUM_STREETS-1:0] pri_pend, pend_n;
  logic                   flash, flash_n;
  logic                   pri_grant, grant_n;
  logic                   served, served_n;
  logic                   tick;
  logic [NUM_STREETS-1:0] act_mask;
  logic [NUM_STREETS-1:0] other_pend;
  logic                   pick_found;
  logic [2:0]             pick_idx;
  logic [2:0]             rr_idx;

  assign tick       = en && (presc == PW'(TICK_DIV - 1));
  assign act_mask   = NUM_STREETS'(1) << active_idx;
  assign other_pend = (pri_pend | pri_req) & ~act_mask;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_STREETS; i++) begin
      if (other_pend[i] && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = 3'(i);
      end
    end
  end

  // Until the first green after reset, rotation starts from street 0 itself
  // rather than from its successor.
  always_comb begin
    if (!served || active_idx == 3'(NUM_STREETS - 1))
      rr_idx = '0;
    else
      rr_idx = active_idx + 3'd1;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = active_idx;
    grant_n  = pri_grant;
    flash_n  = flash;
    served_n = served;
    pend_n   = pri_pend | pri_req;
    if (state == S_GREEN)
      pend_n = pend_n & ~act_mask;
    unique case (state)
      S_ALL_RED: if (tick) begin
        if (cnt == CNT_W'(ALL_RED_TICKS - 1)) begin
          cnt_n = '0;
          if (night_mode) begin
            state_n = S_NIGHT;
          end else begin
            state_n  = S_GREEN;
            served_n = 1'b1;
            if (pick_found) begin
              idx_n   = pick_idx;
              grant_n = 1'b1;
            end else begin
              idx_n   = rr_idx;
              grant_n = 1'b0;
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GREEN: if (tick) begin
        if (cnt == CNT_W'(GREEN_TICKS - 1) ||
            (other_pend != '0 && cnt >= CNT_W'(MIN_GREEN - 1)) ||
            night_mode) begin
          state_n = S_YELLOW;
          cnt_n   = '0;
          grant_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_YELLOW: if (tick) begin
        if (cnt == CNT_W'(YELLOW_TICKS - 1)) begin
          state_n = S_ALL_RED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_NIGHT: if (tick) begin
        if (!night_mode) begin
          state_n = S_ALL_RED;
          cnt_n   = '0;
          flash_n = 1'b1;
        end else begin
          flash_n = ~flash;
        end
      end
      default: state_n = S_ALL_RED;
    endcase
    if (state_n == S_GREEN)
      pend_n = pend_n & ~(NUM_STREETS'(1) << idx_n);
    if (state == S_NIGHT)
      pend_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ALL_RED;
      cnt        <= '0;
      presc      <= '0;
      active_idx <= '0;
      pri_pend   <= '0;
      flash      <= 1'b1;
      pri_grant  <= 1'b0;
      served     <= 1'b0;
    end else if (en) begin
      presc      <= tick ? '0 : presc + PW'(1);
      state      <= state_n;
      cnt        <= cnt_n;
      active_idx <= idx_n;
      pri_pend   <= pend_n;
      flash      <= flash_n;
      pri_grant  <= grant_n;
      served     <= served_n;
    end
  end

  always_comb begin
    lamps = '0;
    for (int unsigned k = 0; k < NUM_STREETS; k++) begin
      lamps[3*k +: 3] = 3'b100;
      unique case (state)
        S_GREEN:  if (3'(k) == active_idx) lamps[3*k +: 3] = 3'b001;
        S_YELLOW: if (3'(k) == active_idx) lamps[3*k +: 3] = 3'b010;
        S_NIGHT:  lamps[3*k +: 3] = {1'b0, flash, 1'b0};
        default:  lamps[3*k +: 3] = 3'b100;
      endcase
    end
  end

  assign pri_lamp = (state == S_GREEN && pri_grant) ? act_mask : '0;

  always_comb begin
    unique case (state)
      S_ALL_RED: remaining = CNT_W'(ALL_RED_TICKS - 1) - cnt;
      S_GREEN:   remaining = CNT_W'(GREEN_TICKS - 1) - cnt;
      S_YELLOW:  remaining = CNT_W'(YELLOW_TICKS - 1) - cnt;
      default:   remaining = '0;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_multi.sv
module tb_traffic_light_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic        night_mode;
  logic [3:0]  pri_req;
  logic [11:0] lamps;
  logic [3:0]  pri_lamp;
  logic [2:0]  active_idx;
  logic [7:0]  remaining;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam logic [11:0] AR  = 12'b100_100_100_100;
  localparam logic [11:0] NON = 12'b010_010_010_010;
  localparam logic [11:0] NOF = 12'b000_000_000_000;

  traffic_light_multi #(
    .NUM_STREETS(4),
    .TICK_DIV(1),
    .GREEN_TICKS(5),
    .MIN_GREEN(2),
    .YELLOW_TICKS(2),
    .ALL_RED_TICKS(1),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .night_mode(night_mode),
    .pri_req(pri_req),
    .lamps(lamps),
    .pri_lamp(pri_lamp),
    .active_idx(active_idx),
    .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        night;
    logic [11:0] lamps;
    logic [3:0]  pl;
    logic [2:0]  idx;
    logic [7:0]  rem;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] grp(input int unsigned st, input logic [2:0] pat);
    logic [11:0] v;
    v = AR;
    v[3*st +: 3] = pat;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pri_req = '0;
    night_mode = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string name, input logic [11:0] el, input logic [3:0] ep,
                     input logic [2:0] ei, input logic [7:0] er);
    n_checks++;
    if (lamps !== el || pri_lamp !== ep || active_idx !== ei || remaining !== er) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got lamps=%b pri=%b idx=%0d rem=%0d, want lamps=%b pri=%b idx=%0d rem=%0d",
               name, cyc, lamps, pri_lamp, active_idx, remaining, el, ep, ei, er);
    end
  endtask

  task automatic run_vectors(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      pri_req    = tbl[i].req;
      night_mode = tbl[i].night;
      chk(name, tbl[i].lamps, tbl[i].pl, tbl[i].idx, tbl[i].rem);
      step();
    end
    pri_req = '0;
  endtask

  // At most one street shows green or yellow, except in flashing night mode.
  always @(negedge clk) begin
    if (!rst) begin
      int unsigned lit;
      lit = 0;
      for (int k = 0; k < 4; k++)
        if (lamps[3*k +: 2] != 2'b00) lit++;
      n_checks++;
      if (lit > 1 && lamps !== NON) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d: lamps=%b has %0d lit groups, want at most 1", cyc, lamps, lit);
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    night_mode = 1'b0;
    pri_req = '0;

    // Normal rotation timeline: all-red, then per street 5 green, 2 yellow, 1 all-red.
    tbl.push_back('{4'b0, 1'b0, AR, 4'b0, 3'd0, 8'd0});
    for (int s = 0; s < 5; s++) begin
      int unsigned st;
      st = s % 4;
      for (int g = 0; g < 5; g++)
        tbl.push_back('{4'b0, 1'b0, grp(st, 3'b001), 4'b0, 3'(st), 8'(4 - g)});
      for (int y = 0; y < 2; y++)
        tbl.push_back('{4'b0, 1'b0, grp(st, 3'b010), 4'b0, 3'(st), 8'(1 - y)});
      tbl.push_back('{4'b0, 1'b0, AR, 4'b0, 3'(st), 8'd0});
    end

    // 1. free-running rotation 0->1->2->3->0
    do_reset();
    run_vectors("rotate", tbl.size());

    // 2. priority for street 2 pulsed in cycle 2
    do_reset();
    chk("pri2_c0", AR, 4'b0, 3'd0, 8'd0); step();
    chk("pri2_c1", grp(0, 3'b001), 4'b0, 3'd0, 8'd4); step();
    chk("pri2_c2", grp(0, 3'b001), 4'b0, 3'd0, 8'd3);
    pri_req = 4'b0100; step(); pri_req = '0;
    chk("pri2_y3", grp(0, 3'b010), 4'b0, 3'd0, 8'd1); step();
    chk("pri2_y4", grp(0, 3'b010), 4'b0, 3'd0, 8'd0); step();
    chk("pri2_ar5", AR, 4'b0, 3'd0, 8'd0); step();
    for (int g = 0; g < 5; g++) begin
      chk("pri2_green", grp(2, 3'b001), 4'b0100, 3'd2, 8'(4 - g)); step();
    end
    chk("pri2_y11", grp(2, 3'b010), 4'b0, 3'd2, 8'd1); step();
    chk("pri2_y12", grp(2, 3'b010), 4'b0, 3'd2, 8'd0); step();
    chk("pri2_ar13", AR, 4'b0, 3'd2, 8'd0); step();
    chk("pri2_next3", grp(3, 3'b001), 4'b0, 3'd3, 8'd4);

    // 3. priority at cnt=0 waits for the minimum green
    do_reset();
    step();
    chk("min_c1", grp(0, 3'b001), 4'b0, 3'd0, 8'd4);
    pri_req = 4'b0010; step(); pri_req = '0;
    chk("min_c2", grp(0, 3'b001), 4'b0, 3'd0, 8'd3); step();
    chk("min_y3", grp(0, 3'b010), 4'b0, 3'd0, 8'd1); step();
    chk("min_y4", grp(0, 3'b010), 4'b0, 3'd0, 8'd0); step();
    chk("min_ar5", AR, 4'b0, 3'd0, 8'd0); step();
    chk("min_g6", grp(1, 3'b001), 4'b0010, 3'd1, 8'd4);

    // 4. night mode; a request during night is discarded
    do_reset();
    step(); step();
    chk("night_c2", grp(0, 3'b001), 4'b0, 3'd0, 8'd3);
    night_mode = 1'b1; step();
    chk("night_y3", grp(0, 3'b010), 4'b0, 3'd0, 8'd1); step();
    chk("night_y4", grp(0, 3'b010), 4'b0, 3'd0, 8'd0); step();
    chk("night_ar5", AR, 4'b0, 3'd0, 8'd0); step();
    for (int c = 6; c <= 20; c++) begin
      chk("night_flash", ((c - 6) % 2 == 0) ? NON : NOF, 4'b0, 3'd0, 8'd0);
      if (c == 10) pri_req = 4'b1000;
      if (c == 20) night_mode = 1'b0;
      step();
      pri_req = '0;
    end
    chk("night_ar21", AR, 4'b0, 3'd0, 8'd0); step();
    chk("night_g22", grp(1, 3'b001), 4'b0, 3'd1, 8'd4);

    // 5a. reset mid-yellow with a pending request clears everything
    do_reset();
    for (int c = 0; c < 6; c++) step();
    pri_req = 4'b1000; step(); pri_req = '0;
    chk("rst_y7", grp(0, 3'b010), 4'b0, 3'd0, 8'd0);
    do_reset();
    run_vectors("after_rst", 10);

    // 5b. clock-enable freeze during green
    do_reset();
    step(); step();
    chk("en_c2", grp(0, 3'b001), 4'b0, 3'd0, 8'd3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en_frozen", grp(0, 3'b001), 4'b0, 3'd0, 8'd3);
    end
    en = 1'b1;
    step(); chk("en_res2", grp(0, 3'b001), 4'b0, 3'd0, 8'd2);
    step(); chk("en_res1", grp(0, 3'b001), 4'b0, 3'd0, 8'd1);
    step(); chk("en_res0", grp(0, 3'b001), 4'b0, 3'd0, 8'd0);
    step(); chk("en_yel", grp(0, 3'b010), 4'b0, 3'd0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
